// File: rtl/regfile_pc_sp_if.sv
// Decode-side bundle for the tiny16 register file:
// selects, write strobe, PC/SP controls and operand returns.
interface regfile_pc_sp_if #(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 3
);
  logic [SEL_W-1:0]  src_sel;
  logic [SEL_W-1:0]  dst_sel;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              pc_inc;
  logic              pc_load;
  logic [DATA_W-1:0] pc_target;
  logic              sp_push;
  logic              sp_pop;
  logic [DATA_W-1:0] src;
  logic [DATA_W-1:0] dst;
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] sp;
  logic              sp_wrap;

  modport master (
    output src_sel, dst_sel, wr_en, wr_data,
    output pc_inc, pc_load, pc_target,
    output sp_push, sp_pop,
    input  src, dst, pc, sp, sp_wrap
  );

  modport slave (
    input  src_sel, dst_sel, wr_en, wr_data,
    input  pc_inc, pc_load, pc_target,
    input  sp_push, sp_pop,
    output src, dst, pc, sp, sp_wrap
  );
endinterface

// File: rtl/regfile_pc_sp.sv
// tiny16 register file: two comb read ports, one write port,
// PC (inc/load) and SP (push/pop) living inside the GPR array.
module regfile_pc_sp #(
  parameter int                DATA_W = 16,
  parameter int                NREG   = 8,
  parameter int                SEL_W  = 3,
  parameter int                PC_IDX = 0,
  parameter int                SP_IDX = 7,
  parameter logic [DATA_W-1:0] PC_RST = '0,
  parameter logic [DATA_W-1:0] SP_RST = DATA_W'(16'h00FF),
  parameter bit                BYPASS = 1'b0
) (
  input  logic clk,
  input  logic rst,
  regfile_pc_sp_if.slave bus
);

  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);
  localparam logic [SEL_W-1:0]  MAX_SEL = SEL_W'(NREG - 1);
  localparam logic [SEL_W-1:0]  PC_SEL = SEL_W'(PC_IDX);
  localparam logic [SEL_W-1:0]  SP_SEL = SEL_W'(SP_IDX);

  logic [DATA_W-1:0] gpr_q [NREG];
  logic [DATA_W-1:0] gpr_d [NREG];
  logic              wrap_q;
  logic              wrap_d;

  logic              wr_ok;
  logic              wr_pc;
  logic              wr_sp;
  logic [DATA_W-1:0] pc_cur;
  logic [DATA_W-1:0] sp_cur;
  logic [DATA_W-1:0] src_rd;
  logic [DATA_W-1:0] dst_rd;

  assign wr_ok  = bus.wr_en && (bus.dst_sel <= MAX_SEL);
  assign wr_pc  = wr_ok && (bus.dst_sel == PC_SEL);
  assign wr_sp  = wr_ok && (bus.dst_sel == SP_SEL);
  assign pc_cur = gpr_q[PC_IDX];
  assign sp_cur = gpr_q[SP_IDX];

  always_comb begin
    src_rd = '0;
    dst_rd = '0;
    for (int i = 0; i < NREG; i++) begin
      if (bus.src_sel == SEL_W'(i)) src_rd = gpr_q[i];
      if (bus.dst_sel == SEL_W'(i)) dst_rd = gpr_q[i];
    end
    // Forwarding only ever carries wr_data, never PC/SP adjustments
    if (BYPASS && wr_ok) begin
      if (bus.src_sel == bus.dst_sel) src_rd = bus.wr_data;
      dst_rd = bus.wr_data;
    end
  end

  always_comb begin
    gpr_d  = gpr_q;
    wrap_d = 1'b0;
    if (wr_ok) begin
      for (int i = 0; i < NREG; i++) begin
        if (bus.dst_sel == SEL_W'(i)) gpr_d[i] = bus.wr_data;
      end
    end
    if (bus.pc_load) begin
      gpr_d[PC_IDX] = bus.pc_target;
    end else if (!wr_pc && bus.pc_inc) begin
      gpr_d[PC_IDX] = pc_cur + ONE;
    end
    if (!wr_sp && (bus.sp_push ^ bus.sp_pop)) begin
      if (bus.sp_push) begin
        gpr_d[SP_IDX] = sp_cur - ONE;
        wrap_d        = (sp_cur == '0);
      end else begin
        gpr_d[SP_IDX] = sp_cur + ONE;
        wrap_d        = &sp_cur;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        gpr_q[i] <= (i == PC_IDX) ? PC_RST :
                    (i == SP_IDX) ? SP_RST : '0;
      end
      wrap_q <= 1'b0;
    end else begin
      gpr_q  <= gpr_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.src     = src_rd;
  assign bus.dst     = dst_rd;
  assign bus.pc      = pc_cur;
  assign bus.sp      = sp_cur;
  assign bus.sp_wrap = wrap_q;

endmodule

// File: tb/tb_regfile_pc_sp.sv
// Scoreboard bench: inst0 = defaults (BYPASS=0), inst1 = NREG 6,
// SP at 5, BYPASS=1; both driven each cycle and checked at negedge.
module tb_regfile_pc_sp;

  typedef struct packed {
    logic [2:0]  src_sel;
    logic [2:0]  dst_sel;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        pc_inc;
    logic        pc_load;
    logic [15:0] pc_target;
    logic        sp_push;
    logic        sp_pop;
  } stim_t;

  typedef struct packed {
    logic [1:0][15:0] src;
    logic [1:0][15:0] dst;
    logic [1:0][15:0] pc;
    logic [1:0][15:0] sp;
    logic [1:0]       wrap;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  regfile_pc_sp_if #(.DATA_W(16), .SEL_W(3)) b0 ();
  regfile_pc_sp_if #(.DATA_W(16), .SEL_W(3)) b1 ();

  regfile_pc_sp #(
    .DATA_W(16), .NREG(8), .SEL_W(3), .PC_IDX(0), .SP_IDX(7),
    .PC_RST(16'h0000), .SP_RST(16'h00FF), .BYPASS(1'b0)
  ) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));

  regfile_pc_sp #(
    .DATA_W(16), .NREG(6), .SEL_W(3), .PC_IDX(0), .SP_IDX(5),
    .PC_RST(16'h0000), .SP_RST(16'h00FF), .BYPASS(1'b1)
  ) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

  always #5 clk = ~clk;

  int   nreg [2] = '{8, 6};
  int   spi  [2] = '{7, 5};
  bit   byp  [2] = '{1'b0, 1'b1};
  logic [15:0] r [2][8];
  bit   w [2];

  exp_t q [$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) r[k][i] = 16'h0000;
      r[k][spi[k]] = 16'h00FF;
      w[k] = 1'b0;
    end
  endfunction

  function automatic logic [15:0] rd(int k, logic [2:0] sel, stim_t s);
    if (int'(sel) >= nreg[k]) return 16'h0000;
    if (byp[k] && s.wr_en && sel == s.dst_sel) return s.wr_data;
    return r[k][sel];
  endfunction

  function automatic void upd(int k, stim_t s);
    logic [15:0] pc = r[k][0];
    logic [15:0] sp = r[k][spi[k]];
    bit inr = int'(s.dst_sel) < nreg[k];
    bit wpc = s.wr_en && inr && s.dst_sel == 3'd0;
    bit wsp = s.wr_en && inr && int'(s.dst_sel) == spi[k];
    if (s.wr_en && inr) r[k][s.dst_sel] = s.wr_data;
    if (s.pc_load) r[k][0] = s.pc_target;
    else if (!wpc && s.pc_inc) r[k][0] = pc + 16'd1;
    w[k] = 1'b0;
    if (!wsp && s.sp_push && !s.sp_pop) begin
      r[k][spi[k]] = sp - 16'd1;
      w[k] = (sp == 16'h0000);
    end else if (!wsp && s.sp_pop && !s.sp_push) begin
      r[k][spi[k]] = sp + 16'd1;
      w[k] = (sp == 16'hFFFF);
    end
  endfunction

  function automatic stim_t mk(logic [2:0] ss, logic [2:0] ds,
                               logic we, logic [15:0] wd,
                               logic inc, logic ld, logic [15:0] tg,
                               logic pu, logic po);
    stim_t s;
    s.src_sel = ss; s.dst_sel = ds; s.wr_en = we; s.wr_data = wd;
    s.pc_inc = inc; s.pc_load = ld; s.pc_target = tg;
    s.sp_push = pu; s.sp_pop = po;
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.src_sel   = 3'($urandom_range(0, 7));
    s.dst_sel   = 3'($urandom_range(0, 7));
    s.wr_en     = ($urandom_range(0, 2) == 0);
    case ($urandom_range(0, 3))
      0:       s.wr_data = 16'h0000;
      1:       s.wr_data = 16'hFFFF;
      default: s.wr_data = 16'($urandom);
    endcase
    s.pc_inc    = 1'($urandom);
    s.pc_load   = ($urandom_range(0, 7) == 0);
    s.pc_target = 16'($urandom);
    s.sp_push   = 1'($urandom);
    s.sp_pop    = 1'($urandom);
    return s;
  endfunction

  task automatic drive(stim_t a, stim_t b);
    b0.src_sel = a.src_sel; b0.dst_sel = a.dst_sel;
    b0.wr_en = a.wr_en; b0.wr_data = a.wr_data;
    b0.pc_inc = a.pc_inc; b0.pc_load = a.pc_load;
    b0.pc_target = a.pc_target;
    b0.sp_push = a.sp_push; b0.sp_pop = a.sp_pop;
    b1.src_sel = b.src_sel; b1.dst_sel = b.dst_sel;
    b1.wr_en = b.wr_en; b1.wr_data = b.wr_data;
    b1.pc_inc = b.pc_inc; b1.pc_load = b.pc_load;
    b1.pc_target = b.pc_target;
    b1.sp_push = b.sp_push; b1.sp_pop = b.sp_pop;
  endtask

  task automatic push_exp(stim_t a, stim_t b);
    exp_t e;
    stim_t s;
    for (int k = 0; k < 2; k++) begin
      s = (k == 0) ? a : b;
      e.src[k]  = rd(k, s.src_sel, s);
      e.dst[k]  = rd(k, s.dst_sel, s);
      e.pc[k]   = r[k][0];
      e.sp[k]   = r[k][spi[k]];
      e.wrap[k] = w[k];
    end
    q.push_back(e);
  endtask

  // dsp steers dst_sel to each instance's own SP index
  task automatic step(stim_t s, bit dsp, bit hold);
    stim_t a, b;
    @(posedge clk);
    #1;
    rst = !hold;
    a = s;
    b = s;
    if (dsp) begin
      a.dst_sel = 3'd7;
      b.dst_sel = 3'd5;
    end
    if (hold) begin
      a.wr_en = 1'b0;
      b.wr_en = 1'b0;
    end
    drive(a, b);
    push_exp(a, b);
    if (!hold) begin
      upd(0, a);
      upd(1, b);
    end
  endtask

  task automatic do_reset();
    stim_t s;
    @(posedge clk);
    #1;
    s = rnd();
    s.wr_en = 1'b1;
    s.sp_push = 1'b1;
    s.pc_inc = 1'b1;
    drive(s, s);
    #2;
    rst = 1'b0;
    s.wr_en = 1'b0;
    drive(s, s);
    model_reset();
    push_exp(s, s);
    step(rnd(), 1'b0, 1'b1);
  endtask

  task automatic chk(string n, int k, logic [15:0] act, logic [15:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s inst%0d t=%0t: got %h expected %h",
               n, k, $time, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("src",  0, b0.src, e.src[0]);
      chk("dst",  0, b0.dst, e.dst[0]);
      chk("pc",   0, b0.pc,  e.pc[0]);
      chk("sp",   0, b0.sp,  e.sp[0]);
      chk("wrap", 0, 16'(b0.sp_wrap), 16'(e.wrap[0]));
      chk("src",  1, b1.src, e.src[1]);
      chk("dst",  1, b1.dst, e.dst[1]);
      chk("pc",   1, b1.pc,  e.pc[1]);
      chk("sp",   1, b1.sp,  e.sp[1]);
      chk("wrap", 1, 16'(b1.sp_wrap), 16'(e.wrap[1]));
    end
  end

  stim_t idle;

  initial begin
    idle = mk(3'd1, 3'd2, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    drive(idle, idle);
    model_reset();
    #1 rst = 1'b0;
    step(idle, 1'b0, 1'b1);
    step(idle, 1'b0, 1'b1);

    // write/read with and without forwarding
    step(mk(3, 3, 1, 16'hABCD, 0, 0, 0, 0, 0), 1'b0, 1'b0);
    step(mk(3, 3, 0, 16'h0, 0, 0, 0, 0, 0), 1'b0, 1'b0);

    // PC priority: load > write > inc
    step(mk(0, 0, 1, 16'h0010, 0, 0, 0, 0, 0), 1'b0, 1'b0);
    step(mk(0, 0, 1, 16'h0300, 1, 1, 16'h0200, 0, 0), 1'b0, 1'b0);
    step(mk(0, 0, 1, 16'h0300, 1, 0, 0, 0, 0), 1'b0, 1'b0);
    step(mk(0, 1, 0, 16'h0, 1, 0, 0, 0, 0), 1'b0, 1'b0);
    step(idle, 1'b0, 1'b0);

    // PC wrap
    step(mk(0, 0, 1, 16'hFFFF, 0, 0, 0, 0, 0), 1'b0, 1'b0);
    step(mk(0, 1, 0, 16'h0, 1, 0, 0, 0, 0), 1'b0, 1'b0);
    step(idle, 1'b0, 1'b0);

    // SP push/pop and wrap flag
    repeat (3) step(mk(1, 2, 0, 0, 0, 0, 0, 1, 0), 1'b0, 1'b0);
    step(mk(1, 2, 0, 0, 0, 0, 0, 1, 1), 1'b0, 1'b0);
    step(idle, 1'b0, 1'b0);
    step(mk(1, 0, 1, 16'h0000, 0, 0, 0, 0, 0), 1'b1, 1'b0);
    step(mk(1, 2, 0, 0, 0, 0, 0, 1, 0), 1'b0, 1'b0);
    step(idle, 1'b0, 1'b0);
    step(mk(1, 2, 0, 0, 0, 0, 0, 0, 1), 1'b0, 1'b0);
    step(idle, 1'b0, 1'b0);
    step(mk(1, 0, 1, 16'h0000, 0, 0, 0, 1, 0), 1'b1, 1'b0);
    step(idle, 1'b0, 1'b0);

    // out-of-range selects
    step(mk(7, 7, 1, 16'h1234, 0, 0, 0, 0, 0), 1'b0, 1'b0);
    step(mk(7, 6, 0, 16'h0, 0, 0, 0, 0, 0), 1'b0, 1'b0);

    do_reset();

    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 149) do_reset();
      else step(rnd(), ($urandom_range(0, 5) == 0), 1'b0);
    end

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
